log2_iter: RTL and testbench

Parametrised iterative base-2 logarithm unit for unsigned integers. It computes the integer part with a leading-one detect, then the fractional part by repeated squaring of the normalised mantissa, one bit per cycle. A start/busy/done handshake lets it sit behind a simple controller, and results are held stable until the next accepted request.

---
 rtl/log2_iter.sv | 125 ++++++++++++
 tb/tb_log2_iter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/log2_iter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | log2_iter                                                              |
// | Iterative unsigned base-2 logarithm: leading-one detect for the        |
// | characteristic, then one mantissa bit per cycle by repeated squaring.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module log2_iter #(
  parameter  int W  = 8,
  parameter  int F  = 5,
  localparam int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  x,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] characteristic,
  output logic [F-1:0]  mantissa,
  output logic          zero_err
);

  localparam int            CNTW     = $clog2(F + 1);
  localparam logic [CW-1:0]   c_top    = CW'(W - 1);
  localparam logic [CNTW-1:0] c_last   = CNTW'(F - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_operand;
  logic [W-1:0]    r_m;
  logic [CNTW-1:0] r_cnt;
  logic [CW-1:0]   r_char;
  logic [F-1:0]    r_mant;
  logic            r_zero_err;

  logic [CW-1:0]   w_msb;
  logic [W-1:0]    w_norm;
  logic [W:0]      w_sq_hi;
  logic            w_bit;
  logic [W-1:0]    w_m_nxt;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < W; i++) begin
      if (r_operand[i]) w_msb = CW'(i);
    end
  end

  assign w_norm = r_operand << (c_top - w_msb);

  // Only the top W+1 bits of the Q2.(2W-2) square are ever needed.
  assign w_sq_hi = (W + 1)'(({{W{1'b0}}, r_m} * {{W{1'b0}}, r_m}) >> (W - 1));
  assign w_bit   = w_sq_hi[W];
  assign w_m_nxt = w_bit ? w_sq_hi[W:1] : w_sq_hi[W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = (r_operand == '0) ? S_DONE : S_ITER;
      S_ITER:  if (r_cnt == c_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_operand  <= '0;
      r_m        <= '0;
      r_cnt      <= '0;
      r_char     <= '0;
      r_mant     <= '0;
      r_zero_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_operand <= x;
            r_cnt     <= '0;
          end
        end
        S_NORM: begin
          r_mant <= '0;
          if (r_operand == '0) begin
            r_zero_err <= 1'b1;
            r_char     <= '0;
          end else begin
            r_zero_err <= 1'b0;
            r_char     <= w_msb;
            r_m        <= w_norm;
          end
        end
        S_ITER: begin
          r_m    <= w_m_nxt;
          r_mant <= F'({r_mant, w_bit});
          r_cnt  <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign characteristic = r_char;
  assign mantissa       = r_mant;
  assign zero_err       = r_zero_err;

endmodule
`default_nettype wire

// File: tb/tb_log2_iter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_log2_iter                                                           |
// | Directed self-checking bench for log2_iter (W=8/F=5 and W=16/F=8).     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_log2_iter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x;
  logic       busy, done, zero_err;
  logic [2:0] characteristic;
  logic [4:0] mantissa;

  logic        start16;
  logic [15:0] x16;
  logic        busy16, done16, zero_err16;
  logic [3:0]  characteristic16;
  logic [7:0]  mantissa16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  log2_iter #(.W(8), .F(5)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .x(x),
    .busy(busy), .done(done), .characteristic(characteristic),
    .mantissa(mantissa), .zero_err(zero_err)
  );

  log2_iter #(.W(16), .F(8)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .x(x16),
    .busy(busy16), .done(done16), .characteristic(characteristic16),
    .mantissa(mantissa16), .zero_err(zero_err16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns the cycle index (accept cycle = 0) in which done is observed.
  task automatic run8(input logic [7:0] xv, output int lat);
    @(negedge clk); start = 1'b1; x = xv;
    @(negedge clk); start = 1'b0; x = 8'hA5;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic run16(input logic [15:0] xv, output int lat);
    @(negedge clk); start16 = 1'b1; x16 = xv;
    @(negedge clk); start16 = 1'b0; x16 = 16'h5A5A;
    lat = 1;
    while (!done16 && lat < 40) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic expect8(input string tag, input logic [7:0] xv,
                         input logic [2:0] c, input logic [4:0] m);
    int lat;
    run8(xv, lat);
    check({tag, "_lat"},  lat, 7);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_char"}, characteristic, c);
    check({tag, "_mant"}, mantissa, m);
    check({tag, "_zerr"}, zero_err, 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  function automatic logic [7:0] cont_x(input int k);
    return 8'(k * 37 + 5);
  endfunction

  initial begin
    int lat;
    logic seen;
    reset = 1'b1; start = 1'b0; x = '0; start16 = 1'b0; x16 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_out", {done, characteristic, mantissa, zero_err}, '0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_out", {busy, done, characteristic, mantissa, zero_err}, '0);

    expect8("x3",   8'd3,   3'd1, 5'b10010);
    expect8("x255", 8'd255, 3'd7, 5'b11111);
    expect8("x128", 8'd128, 3'd7, 5'b00000);
    expect8("x1",   8'd1,   3'd0, 5'b00000);
    expect8("x6",   8'd6,   3'd2, 5'b10010);

    run8(8'd0, lat);
    check("x0_lat",  lat, 2);
    check("x0_zerr", zero_err, 1'b1);
    check("x0_char", characteristic, 3'd0);
    check("x0_mant", mantissa, 5'd0);
    @(negedge clk);
    expect8("x3_after0", 8'd3, 3'd1, 5'b10010);

    // Continuous start: accepts at cycles 0, 8, 16 take x = 5, 45, 85.
    @(negedge clk); start = 1'b1; x = cont_x(0);
    for (int k = 1; k < 24; k++) begin
      @(negedge clk);
      check("cont_done", done, (k == 7 || k == 15 || k == 23));
      if (k == 7 || k == 8 || k == 9) begin
        check("cont_char5", characteristic, 3'd2);
        check("cont_mant5", mantissa, 5'b01010);
      end
      if (k == 15) begin
        check("cont_char45", characteristic, 3'd5);
        check("cont_mant45", mantissa, 5'b01111);
      end
      if (k == 23) begin
        check("cont_char85", characteristic, 3'd6);
        check("cont_mant85", mantissa, 5'b01100);
      end
      x = cont_x(k);
      if (k == 23) start = 1'b0;
    end
    @(negedge clk);

    // Asynchronous reset during ITER.
    @(negedge clk); start = 1'b1; x = 8'd200;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("ar_busy_pre", busy, 1'b1);
    check("ar_char_pre", characteristic, 3'd7);
    #2 reset = 1'b1;
    #1;
    check("ar_busy", busy, 1'b0);
    check("ar_out", {done, characteristic, mantissa, zero_err}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | done;
    end
    check("ar_no_done", seen, 1'b0);
    expect8("ar_x3", 8'd3, 3'd1, 5'b10010);

    run16(16'd1000, lat);
    check("w16_lat",  lat, 10);
    check("w16_char", characteristic16, 4'd9);
    check("w16_mant", mantissa16, 8'b11110111);
    check("w16_zerr", zero_err16, 1'b0);
    @(negedge clk);
    run16(16'd65535, lat);
    check("w16max_lat",  lat, 10);
    check("w16max_char", characteristic16, 4'd15);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
